apb_rr_arbiter: RTL and testbench
=================================

APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 16, APB address width.
REQ-002 SHALL have parameter DATAWIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 0, ACCESS-phase wait limit in PCLKEN cycles (0 = disabled).
REQ-004 SHALL use one clock and an asynchronous, active-low reset (already decided); ports: HCLK  in  1  clock; HRESETn  in  1  reset.
REQ-005 SHALL have port PCLKEN  in  1  APB clock enable; APB phases advance only when high.
REQ-006 SHALL have ports for n=0,1: REQn_VALID  in  1  request; REQn_WRITE  in  1  1=write; REQn_ADDR  in  ADDRWIDTH  address; REQn_WDATA  in  DATAWIDTH  write data.
REQ-007 SHALL have ports for n=0,1: REQn_READY  out  1  request accepted; RSPn_VALID  out  1  one-cycle completion; RSPn_RDATA  out  DATAWIDTH  read data; RSPn_ERR  out  1  error.
REQ-008 SHALL have APB ports: PSEL, PENABLE, PWRITE  out  1; PADDR  out  ADDRWIDTH; PWDATA  out  DATAWIDTH; PRDATA  in  DATAWIDTH; PREADY  in  1; PSLVERR  in  1.
REQ-009 SHALL have port BUSY  out  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, SETUP, ACCESS; PSEL=1 in SETUP/ACCESS, PENABLE=1 only in ACCESS.
REQ-011 SHALL accept exactly one request in IDLE when PCLKEN=1 and any REQn_VALID=1, driving the winner's REQn_READY high combinationally that cycle; transfer occurs when VALID and READY are both high.
REQ-012 SHALL grant round-robin: with both valid, grant the requester not granted last; with one valid, grant it; last-granted pointer updates only on a grant.
REQ-013 SHALL register PADDR/PWRITE/PWDATA from the winner on the accept edge and enter SETUP; PWDATA is loaded on reads too.
REQ-014 SHALL move SETUP->ACCESS on the first PCLKEN=1 cycle in SETUP.
REQ-015 SHALL complete in ACCESS when PCLKEN=1 and PREADY=1: next cycle pulse RSPn_VALID for the granted requester only, with RSPn_RDATA=PRDATA for reads or 0 for writes, and RSPn_ERR=PSLVERR; return to IDLE.
REQ-016 SHALL, when TIMEOUT>0, count PCLKEN=1 ACCESS cycles with PREADY=0 and, on reaching TIMEOUT, complete as in REQ-015 with RSPn_ERR=1 and RSPn_RDATA=0.
REQ-017 SHALL hold RSPn_RDATA/RSPn_ERR until the next completion for that requester; PADDR/PWRITE/PWDATA hold until the next grant.
REQ-018 SHALL never assert REQn_READY outside IDLE or when PCLKEN=0; a requester holds its payload stable while VALID=1 and READY=0.
REQ-019 SHALL give a minimum of 3 cycles from accept to RSPn_VALID, with one IDLE cycle between transfers.
REQ-020 SHALL ignore PREADY/PSLVERR outside ACCESS and ignore deassertion of REQn_VALID after acceptance.

Reset
REQ-021 SHALL, on HRESETn low at any time including mid-transfer, immediately force state IDLE and PSEL, PENABLE, PWRITE, PADDR, PWDATA, REQn_READY, RSPn_VALID, RSPn_RDATA, RSPn_ERR, BUSY and timeout counter to 0.
REQ-022 SHALL reset the last-granted pointer to 1 so that REQ0 wins the first tie.
REQ-023 SHALL not replay or report an in-flight transfer after reset release.

Structure
REQ-024 SHALL place state encodings and the last-grant reset constant in shared package apb_arb_pkg.
REQ-025 SHALL implement grant selection in one sub-module rr_arb2 (2-way round-robin, pointer input, one-hot grant output).

Verification
REQ-026 Single read: REQ0 addr 0x0040, PRDATA=0xDEADBEEF, PREADY=1, PCLKEN=1 -> SETUP, ACCESS, then RSP0_VALID pulse with RSP0_RDATA=0xDEADBEEF, RSP0_ERR=0, 3 cycles after accept.
REQ-027 Tie: REQ0 and REQ1 both valid from reset -> REQ0 granted first, REQ1 second, REQ0 third if still valid.
REQ-028 Wait states: PREADY low 4 ACCESS cycles, PSLVERR=1 at completion, TIMEOUT=0 -> PENABLE held 5 cycles, RSP1_ERR=1.
REQ-029 Timeout: TIMEOUT=8, PREADY stuck 0 -> completion after 8 PCLKEN cycles in ACCESS, RSP_ERR=1, RDATA=0, BUSY low next cycle.
REQ-030 PCLKEN=1 every 2nd cycle -> REQn_READY and phase changes only on PCLKEN=1 cycles; transfer spans 6 HCLK cycles.
REQ-031 Reset asserted in ACCESS -> all outputs 0 asynchronously; no RSPn_VALID after release.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared state encoding and constants for the APB round-robin arbiter
// Purpose: state enum for the APB master FSM, requester count and the
//          reset value of the last-granted pointer.
// Ports:   none (package)
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int NUM_REQ = 2;

    // Pointer resets to requester 1 so requester 0 wins the first tie.
    localparam logic LAST_GNT_RESET = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant selection
// Purpose: pick one of two requesters; on a tie the one not granted last wins.
// Ports:   req      in  [1:0] request vector
//          last_gnt in  1     index of the requester granted last
//          gnt      out [1:0] one-hot grant (all zero when no request)
module rr_arb2
    import apb_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_gnt,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - two-requester round-robin APB master
// Purpose: accepts one request at a time from two requesters, runs it as an
//          APB SETUP/ACCESS transfer paced by PCLKEN, and returns a one-cycle
//          completion pulse to the owning requester.
// Ports:   HCLK, HRESETn          clock, async active-low reset
//          PCLKEN                 APB phase enable
//          REQn_VALID/WRITE/ADDR/WDATA  request payload (n = 0,1)
//          REQn_READY             combinational accept strobe
//          RSPn_VALID/RDATA/ERR   completion pulse, held read data and error
//          PSEL..PSLVERR          APB master interface
//          BUSY                   high while a transfer is in flight
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 PCLKEN,

    input  logic                 REQ0_VALID,
    input  logic                 REQ0_WRITE,
    input  logic [ADDRWIDTH-1:0] REQ0_ADDR,
    input  logic [DATAWIDTH-1:0] REQ0_WDATA,
    output logic                 REQ0_READY,
    output logic                 RSP0_VALID,
    output logic [DATAWIDTH-1:0] RSP0_RDATA,
    output logic                 RSP0_ERR,

    input  logic                 REQ1_VALID,
    input  logic                 REQ1_WRITE,
    input  logic [ADDRWIDTH-1:0] REQ1_ADDR,
    input  logic [DATAWIDTH-1:0] REQ1_WDATA,
    output logic                 REQ1_READY,
    output logic                 RSP1_VALID,
    output logic [DATAWIDTH-1:0] RSP1_RDATA,
    output logic                 RSP1_ERR,

    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic [DATAWIDTH-1:0] PWDATA,
    input  logic [DATAWIDTH-1:0] PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR,

    output logic                 BUSY
);

    // Wait counter only needs to reach TIMEOUT-1; keep at least one bit so
    // the TIMEOUT=0 build still elaborates.
    localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LIMIT);

    apb_state_e           state_q;
    apb_state_e           state_d;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   gnt;
    logic                 last_gnt_q;
    logic                 owner_q;
    logic                 accept;
    logic                 complete;
    logic                 timed_out;
    logic [CNT_W-1:0]     wait_cnt_q;
    logic [CNT_W-1:0]     wait_cnt_d;

    logic                 pwrite_q;
    logic [ADDRWIDTH-1:0] paddr_q;
    logic [DATAWIDTH-1:0] pwdata_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [NUM_REQ-1:0]   rsp_err_q;
    logic [DATAWIDTH-1:0] rsp0_rdata_q;
    logic [DATAWIDTH-1:0] rsp1_rdata_q;
    logic [DATAWIDTH-1:0] rsp_rdata;

    assign req_valid = {REQ1_VALID, REQ0_VALID};

    rr_arb2 u_rr_arb2 (
        .req      (req_valid),
        .last_gnt (last_gnt_q),
        .gnt      (gnt)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        complete   = 1'b0;
        timed_out  = 1'b0;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (PCLKEN && (|req_valid)) begin
                    accept     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (PCLKEN) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (PCLKEN) begin
                    if (PREADY) begin
                        complete   = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else if (TIMEOUT > 0) begin
                        if (wait_cnt_q == TO_LAST) begin
                            complete   = 1'b1;
                            timed_out  = 1'b1;
                            wait_cnt_d = '0;
                            state_d    = ST_IDLE;
                        end else begin
                            wait_cnt_d = wait_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data returned to the requester: a timeout or a write returns zero.
    assign rsp_rdata = (timed_out || pwrite_q) ? '0 : PRDATA;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_gnt_q   <= LAST_GNT_RESET;
            owner_q      <= 1'b0;
            wait_cnt_q   <= '0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= '0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            rsp_valid_q <= '0;
            wait_cnt_q  <= wait_cnt_d;
            if (accept) begin
                owner_q    <= gnt[1];
                last_gnt_q <= gnt[1];
                pwrite_q   <= gnt[1] ? REQ1_WRITE : REQ0_WRITE;
                paddr_q    <= gnt[1] ? REQ1_ADDR  : REQ0_ADDR;
                pwdata_q   <= gnt[1] ? REQ1_WDATA : REQ0_WDATA;
            end
            if (complete) begin
                if (owner_q) begin
                    rsp_valid_q[1] <= 1'b1;
                    rsp_err_q[1]   <= timed_out | PSLVERR;
                    rsp1_rdata_q   <= rsp_rdata;
                end else begin
                    rsp_valid_q[0] <= 1'b1;
                    rsp_err_q[0]   <= timed_out | PSLVERR;
                    rsp0_rdata_q   <= rsp_rdata;
                end
            end
        end
    end

    // READY is combinational; gating with HRESETn keeps it low during reset
    // even though the requesters may still be driving VALID.
    assign REQ0_READY = accept & gnt[0] & HRESETn;
    assign REQ1_READY = accept & gnt[1] & HRESETn;

    assign RSP0_VALID = rsp_valid_q[0];
    assign RSP1_VALID = rsp_valid_q[1];
    assign RSP0_ERR   = rsp_err_q[0];
    assign RSP1_ERR   = rsp_err_q[1];
    assign RSP0_RDATA = rsp0_rdata_q;
    assign RSP1_RDATA = rsp1_rdata_q;

    assign PSEL    = (state_q != ST_IDLE);
    assign PENABLE = (state_q == ST_ACCESS);
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb/tb_apb_rr_arbiter.sv - directed self-checking bench for apb_rr_arbiter
module tb_apb_rr_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          PCLKEN;
    logic          REQ0_VALID, REQ0_WRITE, REQ1_VALID, REQ1_WRITE;
    logic [AW-1:0] REQ0_ADDR, REQ1_ADDR;
    logic [DW-1:0] REQ0_WDATA, REQ1_WDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY, PSLVERR;

    logic          a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_rsp0_err, a_rsp1_err;
    logic [DW-1:0] a_rsp0_rdata, a_rsp1_rdata, a_pwdata;
    logic          a_psel, a_penable, a_pwrite, a_busy;
    logic [AW-1:0] a_paddr;

    logic          b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_rsp0_err, b_rsp1_err;
    logic [DW-1:0] b_rsp0_rdata, b_rsp1_rdata, b_pwdata;
    logic          b_psel, b_penable, b_pwrite, b_busy;
    logic [AW-1:0] b_paddr;

    int checks = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    apb_rr_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN),
        .REQ0_VALID(REQ0_VALID), .REQ0_WRITE(REQ0_WRITE), .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA),
        .REQ0_READY(a_req0_ready), .RSP0_VALID(a_rsp0_valid), .RSP0_RDATA(a_rsp0_rdata), .RSP0_ERR(a_rsp0_err),
        .REQ1_VALID(REQ1_VALID), .REQ1_WRITE(REQ1_WRITE), .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA),
        .REQ1_READY(a_req1_ready), .RSP1_VALID(a_rsp1_valid), .RSP1_RDATA(a_rsp1_rdata), .RSP1_ERR(a_rsp1_err),
        .PSEL(a_psel), .PENABLE(a_penable), .PWRITE(a_pwrite), .PADDR(a_paddr), .PWDATA(a_pwdata),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .BUSY(a_busy)
    );

    apb_rr_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(8)) dut_to (
        .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN),
        .REQ0_VALID(REQ0_VALID), .REQ0_WRITE(REQ0_WRITE), .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA),
        .REQ0_READY(b_req0_ready), .RSP0_VALID(b_rsp0_valid), .RSP0_RDATA(b_rsp0_rdata), .RSP0_ERR(b_rsp0_err),
        .REQ1_VALID(REQ1_VALID), .REQ1_WRITE(REQ1_WRITE), .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA),
        .REQ1_READY(b_req1_ready), .RSP1_VALID(b_rsp1_valid), .RSP1_RDATA(b_rsp1_rdata), .RSP1_ERR(b_rsp1_err),
        .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite), .PADDR(b_paddr), .PWDATA(b_pwdata),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .BUSY(b_busy)
    );

    task automatic idle_inputs();
        PCLKEN = 1'b1;
        REQ0_VALID = 1'b0; REQ0_WRITE = 1'b0; REQ0_ADDR = '0; REQ0_WDATA = '0;
        REQ1_VALID = 1'b0; REQ1_WRITE = 1'b0; REQ1_ADDR = '0; REQ1_WDATA = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        HRESETn = 1'b0;
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; PREADY = 1'b1;
        @(negedge HCLK);
        checks++; if (a_req0_ready !== 1'b0) begin failures++; $display("FAIL reset_req0_ready got=%b exp=0", a_req0_ready); end
        checks++; if (a_req1_ready !== 1'b0) begin failures++; $display("FAIL reset_req1_ready got=%b exp=0", a_req1_ready); end
        checks++; if (a_psel !== 1'b0) begin failures++; $display("FAIL reset_psel got=%b exp=0", a_psel); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
        checks++; if (a_paddr !== 16'h0000) begin failures++; $display("FAIL reset_paddr got=%h exp=0000", a_paddr); end
        checks++; if (a_rsp0_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp0_valid got=%b exp=0", a_rsp0_valid); end
        next_cycle();
        idle_inputs();
        HRESETn = 1'b1;
    endtask

    task automatic test_single_read();
        apply_reset();
        REQ0_VALID = 1'b1; REQ0_WRITE = 1'b0; REQ0_ADDR = 16'h0040; REQ0_WDATA = 32'h0000_1111;
        PRDATA = 32'hDEAD_BEEF; PREADY = 1'b1;
        @(negedge HCLK);
        checks++; if (a_req0_ready !== 1'b1) begin failures++; $display("FAIL read_req0_ready got=%b exp=1", a_req0_ready); end
        checks++; if (a_req1_ready !== 1'b0) begin failures++; $display("FAIL read_req1_ready got=%b exp=0", a_req1_ready); end
        next_cycle();
        REQ0_VALID = 1'b0;
        @(negedge HCLK);
        checks++; if (a_psel !== 1'b1 || a_penable !== 1'b0) begin failures++; $display("FAIL read_setup psel=%b penable=%b exp=1,0", a_psel, a_penable); end
        checks++; if (a_paddr !== 16'h0040) begin failures++; $display("FAIL read_paddr got=%h exp=0040", a_paddr); end
        checks++; if (a_pwrite !== 1'b0) begin failures++; $display("FAIL read_pwrite got=%b exp=0", a_pwrite); end
        checks++; if (a_pwdata !== 32'h0000_1111) begin failures++; $display("FAIL read_pwdata got=%h exp=00001111", a_pwdata); end
        next_cycle();
        @(negedge HCLK);
        checks++; if (a_psel !== 1'b1 || a_penable !== 1'b1) begin failures++; $display("FAIL read_access psel=%b penable=%b exp=1,1", a_psel, a_penable); end
        next_cycle();
        @(negedge HCLK);
        checks++; if (a_rsp0_valid !== 1'b1) begin failures++; $display("FAIL read_rsp0_valid got=%b exp=1", a_rsp0_valid); end
        checks++; if (a_rsp0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_rsp0_rdata got=%h exp=deadbeef", a_rsp0_rdata); end
        checks++; if (a_rsp0_err !== 1'b0) begin failures++; $display("FAIL read_rsp0_err got=%b exp=0", a_rsp0_err); end
        checks++; if (a_rsp1_valid !== 1'b0) begin failures++; $display("FAIL read_rsp1_valid got=%b exp=0", a_rsp1_valid); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL read_busy_done got=%b exp=0", a_busy); end
        next_cycle();
        @(negedge HCLK);
        checks++; if (a_rsp0_valid !== 1'b0) begin failures++; $display("FAIL read_rsp0_pulse got=%b exp=0", a_rsp0_valid); end
        checks++; if (a_rsp0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_rdata_hold got=%h exp=deadbeef", a_rsp0_rdata); end
        checks++; if (a_paddr !== 16'h0040) begin failures++; $display("FAIL read_paddr_hold got=%h exp=0040", a_paddr); end
        next_cycle();
    endtask

    task automatic test_tie();
        apply_reset();
        REQ0_VALID = 1'b1; REQ0_WRITE = 1'b1; REQ0_ADDR = 16'h0100; REQ0_WDATA = 32'hA0A0_A0A0;
        REQ1_VALID = 1'b1; REQ1_WRITE = 1'b0; REQ1_ADDR = 16'h0200;
        PRDATA = 32'h0000_BEEF; PREADY = 1'b1;
        for (int g = 0; g < 3; g++) begin
            logic w;
            logic prev;
            logic [AW-1:0] exp_addr;
            w = (g == 1);
            prev = (g == 2);
            exp_addr = w ? 16'h0200 : 16'h0100;
            @(negedge HCLK);
            checks++; if (a_req0_ready !== !w || a_req1_ready !== w) begin failures++; $display("FAIL tie_grant%0d ready0=%b ready1=%b exp_winner=%0d", g, a_req0_ready, a_req1_ready, w); end
            if (g > 0) begin
                checks++; if ((prev ? a_rsp1_valid : a_rsp0_valid) !== 1'b1) begin failures++; $display("FAIL tie_rsp%0d got rsp0=%b rsp1=%b exp prev=%0d", g, a_rsp0_valid, a_rsp1_valid, prev); end
            end
            next_cycle();
            @(negedge HCLK);
            checks++; if (a_paddr !== exp_addr) begin failures++; $display("FAIL tie_paddr%0d got=%h exp=%h", g, a_paddr, exp_addr); end
            next_cycle();
            next_cycle();
        end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        @(negedge HCLK);
        checks++; if (a_rsp0_valid !== 1'b1) begin failures++; $display("FAIL tie_rsp_last got=%b exp=1", a_rsp0_valid); end
        checks++; if (a_rsp0_rdata !== 32'h0) begin failures++; $display("FAIL tie_write_rdata got=%h exp=0", a_rsp0_rdata); end
        checks++; if (a_rsp1_rdata !== 32'h0000_BEEF) begin failures++; $display("FAIL tie_read_rdata got=%h exp=0000beef", a_rsp1_rdata); end
        next_cycle();
    endtask

    task automatic test_wait_states();
        int pen;
        apply_reset();
        REQ1_VALID = 1'b1; REQ1_WRITE = 1'b1; REQ1_ADDR = 16'h0ABC; REQ1_WDATA = 32'h1234_5678;
        @(negedge HCLK);
        checks++; if (a_req1_ready !== 1'b1) begin failures++; $display("FAIL wait_req1_ready got=%b exp=1", a_req1_ready); end
        next_cycle();
        REQ1_VALID = 1'b0; PREADY = 1'b1; PSLVERR = 1'b1;
        @(negedge HCLK);
        checks++; if (a_pwdata !== 32'h1234_5678 || a_pwrite !== 1'b1) begin failures++; $display("FAIL wait_setup pwdata=%h pwrite=%b exp=12345678,1", a_pwdata, a_pwrite); end
        checks++; if (a_penable !== 1'b0) begin failures++; $display("FAIL wait_setup_penable got=%b exp=0", a_penable); end
        next_cycle();
        pen = 0;
        for (int i = 0; i < 5; i++) begin
            PREADY = (i == 4);
            PSLVERR = (i == 4);
            @(negedge HCLK);
            if (a_penable === 1'b1) pen++;
            next_cycle();
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
        checks++; if (pen !== 5) begin failures++; $display("FAIL wait_penable_cycles got=%0d exp=5", pen); end
        @(negedge HCLK);
        checks++; if (a_penable !== 1'b0) begin failures++; $display("FAIL wait_penable_done got=%b exp=0", a_penable); end
        checks++; if (a_rsp1_valid !== 1'b1 || a_rsp0_valid !== 1'b0) begin failures++; $display("FAIL wait_rsp_valid rsp0=%b rsp1=%b exp=0,1", a_rsp0_valid, a_rsp1_valid); end
        checks++; if (a_rsp1_err !== 1'b1) begin failures++; $display("FAIL wait_rsp1_err got=%b exp=1", a_rsp1_err); end
        checks++; if (a_rsp1_rdata !== 32'h0) begin failures++; $display("FAIL wait_rsp1_rdata got=%h exp=0", a_rsp1_rdata); end
        next_cycle();
    endtask

    task automatic test_timeout();
        int pen;
        apply_reset();
        REQ0_VALID = 1'b1; REQ0_WRITE = 1'b0; REQ0_ADDR = 16'h0044;
        PRDATA = 32'hCAFE_F00D; PREADY = 1'b0;
        @(negedge HCLK);
        checks++; if (b_req0_ready !== 1'b1) begin failures++; $display("FAIL to_req0_ready got=%b exp=1", b_req0_ready); end
        next_cycle();
        REQ0_VALID = 1'b0;
        next_cycle();
        pen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge HCLK);
            if (b_penable === 1'b1 && b_rsp0_valid === 1'b0) pen++;
            next_cycle();
        end
        @(negedge HCLK);
        checks++; if (pen !== 8) begin failures++; $display("FAIL to_access_cycles got=%0d exp=8", pen); end
        checks++; if (b_rsp0_valid !== 1'b1) begin failures++; $display("FAIL to_rsp0_valid got=%b exp=1", b_rsp0_valid); end
        checks++; if (b_rsp0_err !== 1'b1) begin failures++; $display("FAIL to_rsp0_err got=%b exp=1", b_rsp0_err); end
        checks++; if (b_rsp0_rdata !== 32'h0) begin failures++; $display("FAIL to_rsp0_rdata got=%h exp=0", b_rsp0_rdata); end
        checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL to_busy got=%b exp=0", b_busy); end
        checks++; if (a_busy !== 1'b1 || a_penable !== 1'b1) begin failures++; $display("FAIL to_disabled busy=%b penable=%b exp=1,1", a_busy, a_penable); end
        checks++; if (a_rsp0_valid !== 1'b0) begin failures++; $display("FAIL to_disabled_rsp got=%b exp=0", a_rsp0_valid); end
        next_cycle();
    endtask

    task automatic test_pclken_half();
        logic [6:0] e_ready, e_psel, e_pen, e_rsp;
        apply_reset();
        e_ready = 7'b0000010;
        e_psel  = 7'b0111100;
        e_pen   = 7'b0110000;
        e_rsp   = 7'b1000000;
        REQ1_VALID = 1'b1; REQ1_WRITE = 1'b0; REQ1_ADDR = 16'h0300;
        PRDATA = 32'h5A5A_0001; PREADY = 1'b1;
        for (int c = 0; c < 7; c++) begin
            PCLKEN = ((c % 2) == 1);
            if (c == 2) REQ1_VALID = 1'b0;
            @(negedge HCLK);
            checks++; if (a_req1_ready !== e_ready[c]) begin failures++; $display("FAIL half_ready c%0d got=%b exp=%b", c, a_req1_ready, e_ready[c]); end
            checks++; if (a_psel !== e_psel[c]) begin failures++; $display("FAIL half_psel c%0d got=%b exp=%b", c, a_psel, e_psel[c]); end
            checks++; if (a_penable !== e_pen[c]) begin failures++; $display("FAIL half_penable c%0d got=%b exp=%b", c, a_penable, e_pen[c]); end
            checks++; if (a_rsp1_valid !== e_rsp[c]) begin failures++; $display("FAIL half_rsp1 c%0d got=%b exp=%b", c, a_rsp1_valid, e_rsp[c]); end
            next_cycle();
        end
        checks++; if (a_rsp1_rdata !== 32'h5A5A_0001) begin failures++; $display("FAIL half_rdata got=%h exp=5a5a0001", a_rsp1_rdata); end
        PCLKEN = 1'b1;
    endtask

    task automatic test_async_reset();
        int seen;
        idle_inputs();
        REQ0_VALID = 1'b1; REQ0_WRITE = 1'b1; REQ0_ADDR = 16'h0F0F; REQ0_WDATA = 32'h8765_4321;
        @(negedge HCLK);
        checks++; if (a_req0_ready !== 1'b1) begin failures++; $display("FAIL ar_req0_ready got=%b exp=1", a_req0_ready); end
        next_cycle();
        next_cycle();
        @(negedge HCLK);
        checks++; if (a_penable !== 1'b1 || a_paddr !== 16'h0F0F) begin failures++; $display("FAIL ar_in_access penable=%b paddr=%h exp=1,0f0f", a_penable, a_paddr); end
        #2 HRESETn = 1'b0;
        #1;
        checks++; if (a_psel !== 1'b0 || a_penable !== 1'b0) begin failures++; $display("FAIL ar_apb_ctl psel=%b penable=%b exp=0,0", a_psel, a_penable); end
        checks++; if (a_pwrite !== 1'b0 || a_paddr !== 16'h0 || a_pwdata !== 32'h0) begin failures++; $display("FAIL ar_apb_data pwrite=%b paddr=%h pwdata=%h exp=0", a_pwrite, a_paddr, a_pwdata); end
        checks++; if (a_busy !== 1'b0 || a_req0_ready !== 1'b0) begin failures++; $display("FAIL ar_busy_ready busy=%b ready0=%b exp=0,0", a_busy, a_req0_ready); end
        checks++; if (a_rsp1_rdata !== 32'h0 || a_rsp1_err !== 1'b0) begin failures++; $display("FAIL ar_rsp1 rdata=%h err=%b exp=0,0", a_rsp1_rdata, a_rsp1_err); end
        next_cycle();
        HRESETn = 1'b1;
        REQ0_VALID = 1'b0; PREADY = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            if (a_rsp0_valid !== 1'b0 || a_busy !== 1'b0) seen++;
            next_cycle();
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL ar_no_replay got=%0d exp=0", seen); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_tie();
        test_wait_states();
        test_timeout();
        test_pclken_half();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
